dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Memory-stage responder that consumes the M-stage memory request (mem_en/ren/wen/op/addr/wdata) latched by the EX/MEM pipeline register.
- Converts the request into an SRAM-like data-bus transaction with an address phase and a data phase.
- Raises a pipeline stall while the access is outstanding, then returns byte-lane-aligned, sign- or zero-extended load data and address-error flags for the M-stage exception logic.
- Sits between the EX/MEM register and the data cache/AXI bridge.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus data width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- M_mem_en  in  1  memory access valid in the M stage.
- M_mem_ren  in  1  load.
- M_mem_wen  in  1  store.
- M_mem_op  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011.
- M_mem_addr  in  32  byte address.
- M_mem_wdata  in  32  store data, right-aligned.
- M_flush  in  1  exception/eret flush of the M stage.
- M_pipe_ena  in  1  M→W stage advance this cycle.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus address.
- data_wstrb  out  4  byte-lane strobes.
- data_wdata  out  32  lane-replicated store data.
- data_addr_ok  in  1  address phase accepted.
- data_data_ok  in  1  data phase done; data_rdata is valid.
- data_rdata  in  32  read data.
- M_mem_stall  out  1  stall request to the hazard unit.
- M_mem_rdata  out  32  extended load result.
- M_adel  out  1  load address error.
- M_ades  out  1  store address error.
- M_badvaddr  out  32  faulting address.

Behaviour:

States: IDLE, ADDR, DATA, DONE, DRAIN.

Reset:
- state = IDLE.
- M_mem_rdata = 0.
- All outputs 0.

Misalignment:
- mis = (half op and addr[0]) or (word op and addr[1:0] != 0).
- M_adel = mem_en & ren & mis; M_ades = mem_en & wen & mis. Both combinational.
- M_badvaddr = M_mem_addr when either flag is set, else 0.

Issue condition:
- go = mem_en & !mis & !M_flush.

data_req (combinational):
- Asserted when (state == IDLE & go) or state == ADDR.
- data_addr, data_wr, data_size, data_wstrb and data_wdata are driven from the M_mem_* inputs. The upstream register holds them stable while stalled.

Transitions:
- IDLE: if go, then addr_ok → DATA, else → ADDR.
- ADDR: M_flush → IDLE (request withdrawn; legal only before addr_ok). Otherwise addr_ok → DATA.
- DATA: on data_ok, capture the extended load into M_mem_rdata (stores capture 0).
  - If M_flush was seen this cycle or earlier → IDLE and the data is discarded.
  - Otherwise → DONE.
  - M_flush during DATA without data_ok → DRAIN.
- DRAIN: data_req = 0. Wait for data_ok, discard it, → IDLE.
- DONE: M_pipe_ena → IDLE. M_flush → IDLE.

M_mem_stall:
- 1 when mem_en & !mis & !M_flush and state is not DONE.
- Also 1 in DRAIN whenever mem_en.
- Minimum load-to-use latency: request in cycle 0, data_ok in cycle 1, DONE with stall low in cycle 2.
- Simultaneous addr_ok and data_ok for the same request in IDLE are not allowed; data_ok is honoured only in DATA or DRAIN.

Stores:
- SB: size 0, wstrb = 1 << addr[1:0], wdata = byte replicated 4×.
- SH: size 1, wstrb = 0011 or 1100 by addr[1], wdata = half replicated 2×.
- SW: size 2, wstrb = 1111.
- Loads: wstrb = 0000, data_wr = 0.

Loads (little-endian lane select by addr[1:0]):
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the word through.

Reset asserted mid-transaction → IDLE immediately. The bus side is reset by the same rst.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: misalignment detection as above. A misaligned access issues no request and does not stall.
- Undefined: mis forced to 0, M_adel/M_ades/M_badvaddr tied to 0, and data_addr low bits are cleared: [0] for half, [1:0] for word.

Test Plan:
1. LW addr 0x1000_0004, addr_ok in cycle 0, data_ok in cycle 1 with rdata 0xDEADBEEF → stall high in cycles 0-1, low in cycle 2; M_mem_rdata = 0xDEADBEEF.
2. LB addr 0x…03, rdata 0x80FF_FFFF → M_mem_rdata = 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
3. SH addr 0x…02, wdata 0x0000_1234 → data_wr = 1, size = 1, wstrb = 1100, data_wdata = 0x1234_1234; stall released after data_ok.
4. With DMEM_ALIGN_CHECK_EN: LW addr 0x…02 → M_adel = 1, M_badvaddr = 0x…02, data_req never asserted, stall = 0. SW addr 0x…01 → M_ades = 1.
5. Flush in DATA before data_ok → state DRAIN, data_req = 0. A new load arriving stalls until the stale data_ok returns, then issues normally. The stale data never appears on M_mem_rdata.
6. addr_ok withheld for 3 cycles → data_req held high with stable address and stall held high. rst pulsed low mid-ADDR → all outputs 0 and state IDLE asynchronously.

Source files
------------

// File: rtl/dmem_access_unit.sv
// M-stage memory responder: turns the EX/MEM load/store request into an SRAM-like
// two-phase bus transaction. Optional macro DMEM_ALIGN_CHECK_EN enables address-error detection.
module dmem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              M_mem_en,
  input  logic              M_mem_ren,
  input  logic              M_mem_wen,
  input  logic [5:0]        M_mem_op,
  input  logic [ADDR_W-1:0] M_mem_addr,
  input  logic [DATA_W-1:0] M_mem_wdata,
  input  logic              M_flush,
  input  logic              M_pipe_ena,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              M_mem_stall,
  output logic [DATA_W-1:0] M_mem_rdata,
  output logic              M_adel,
  output logic              M_ades,
  output logic [ADDR_W-1:0] M_badvaddr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              is_byte_s, is_half_s, is_word_s, is_unsigned_s;
  logic              mis_s, go_s;
  logic [ADDR_W-1:0] addr_eff_s;
  logic              unused_s;

  function automatic logic [31:0] load_extend(input logic [31:0] rd, input logic [1:0] lane,
                                              input logic byte_op, input logic half_op,
                                              input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    if (byte_op) begin
      load_extend = {{24{b[7] & ~uns}}, b};
    end else if (half_op) begin
      load_extend = {{16{h[15] & ~uns}}, h};
    end else begin
      load_extend = rd;
    end
  endfunction

  // Access width from the low opcode bits: 00 byte, 01 half, 11 word.
  always_comb begin
    is_byte_s = 1'b0;
    is_half_s = 1'b0;
    is_word_s = 1'b0;
    case (M_mem_op[1:0])
      2'b00:   is_byte_s = 1'b1;
      2'b01:   is_half_s = 1'b1;
      default: is_word_s = 1'b1;
    endcase
  end

  assign is_unsigned_s = M_mem_op[2];
  assign unused_s      = &{1'b0, M_mem_op[5:3]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign mis_s      = (is_half_s & M_mem_addr[0]) | (is_word_s & (M_mem_addr[1:0] != 2'b00));
  assign addr_eff_s = M_mem_addr;
  assign M_adel     = M_mem_en & M_mem_ren & mis_s;
  assign M_ades     = M_mem_en & M_mem_wen & mis_s;
  assign M_badvaddr = (M_adel | M_ades) ? M_mem_addr : '0;
`else
  assign mis_s      = 1'b0;
  assign M_adel     = 1'b0;
  assign M_ades     = 1'b0;
  assign M_badvaddr = '0;

  // Without checking, misaligned halves/words are forced onto their natural boundary.
  always_comb begin
    addr_eff_s = M_mem_addr;
    if (is_half_s) begin
      addr_eff_s[0] = 1'b0;
    end else if (is_word_s) begin
      addr_eff_s[1:0] = 2'b00;
    end else begin
      addr_eff_s = M_mem_addr;
    end
  end
`endif

  assign go_s      = M_mem_en & ~mis_s & ~M_flush;
  assign data_req  = ((state_q == S_IDLE) & go_s) | (state_q == S_ADDR);
  assign data_wr   = M_mem_wen;
  assign data_addr = addr_eff_s;

  // Store lane strobes and replicated write data; loads drive no strobes.
  always_comb begin
    data_size  = 2'd2;
    data_wstrb = 4'b1111;
    data_wdata = M_mem_wdata;
    if (is_byte_s) begin
      data_size  = 2'd0;
      data_wstrb = 4'b0001 << addr_eff_s[1:0];
      data_wdata = {4{M_mem_wdata[7:0]}};
    end else if (is_half_s) begin
      data_size  = 2'd1;
      data_wstrb = addr_eff_s[1] ? 4'b1100 : 4'b0011;
      data_wdata = {2{M_mem_wdata[15:0]}};
    end else begin
      data_size  = 2'd2;
      data_wstrb = 4'b1111;
      data_wdata = M_mem_wdata;
    end
    if (!M_mem_wen) begin
      data_wstrb = 4'b0000;
    end else begin
      data_wstrb = data_wstrb;
    end
  end

  // A flushed access still owes one data_ok; DRAIN swallows it so it cannot reach the pipeline.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (go_s) begin
          state_d = data_addr_ok ? S_DATA : S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (M_flush) begin
          state_d = S_IDLE;
        end else if (data_addr_ok) begin
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (data_data_ok) begin
          if (M_flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            rdata_d = M_mem_ren ? load_extend(data_rdata, addr_eff_s[1:0], is_byte_s,
                                              is_half_s, is_unsigned_s) : '0;
          end
        end else if (M_flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DONE: begin
        if (M_pipe_ena | M_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DRAIN: begin
        if (data_data_ok) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign M_mem_stall = (go_s & (state_q != S_DONE)) | ((state_q == S_DRAIN) & M_mem_en);
  assign M_mem_rdata = rdata_q;

  // State and load-result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed vector table, hand-written
// flush/drain/reset sequences, and randomized transactions against a behavioural model.
module tb_dmem_access_unit;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk = 1'b0;
  logic        rst;
  logic        M_mem_en, M_mem_ren, M_mem_wen, M_flush, M_pipe_ena;
  logic [5:0]  M_mem_op;
  logic [31:0] M_mem_addr, M_mem_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        M_mem_stall, M_adel, M_ades;
  logic [31:0] M_mem_rdata, M_badvaddr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rdata;

  dmem_access_unit dut (
    .clk(clk), .rst(rst),
    .M_mem_en(M_mem_en), .M_mem_ren(M_mem_ren), .M_mem_wen(M_mem_wen),
    .M_mem_op(M_mem_op), .M_mem_addr(M_mem_addr), .M_mem_wdata(M_mem_wdata),
    .M_flush(M_flush), .M_pipe_ena(M_pipe_ena),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .M_mem_stall(M_mem_stall), .M_mem_rdata(M_mem_rdata),
    .M_adel(M_adel), .M_ades(M_ades), .M_badvaddr(M_badvaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int nbytes(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      default:              return 4;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [31:0] m_addr(input logic [5:0] op, input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return a;
`else
    return a - (a % nbytes(op));
`endif
  endfunction

  function automatic logic [1:0] m_size(input logic [5:0] op);
    return (nbytes(op) == 1) ? 2'd0 : (nbytes(op) == 2) ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [3:0] m_strb(input logic [5:0] op, input logic [31:0] a);
    int s;
    if (!is_store(op)) return 4'b0000;
    s = ((1 << nbytes(op)) - 1) << (m_addr(op, a) % 4);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] wd);
    longint unsigned span, v, r;
    int nb;
    nb   = nbytes(op);
    span = 64'd1 << (8 * nb);
    v    = {32'h0, wd} % span;
    r    = 64'd0;
    for (int k = 0; k < 4 / nb; k++) r = r | (v << (8 * nb * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint unsigned span, v;
    int lane;
    if (is_store(op)) return 32'h0;
    lane = int'(m_addr(op, a) % 4);
    span = 64'd1 << (8 * nbytes(op));
    v    = ({32'h0, rd} >> (8 * lane)) % span;
    if (((op == OP_LB) || (op == OP_LH)) && (v >= span / 2)) v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  // ---------------- transaction driver ----------------
  task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int a_dly, input int d_dly,
                         input logic [31:0] e_addr, input logic [1:0] e_size,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input logic [31:0] e_rdata);
    logic st;
    st = is_store(op);
    M_mem_en = 1'b1; M_mem_ren = ~st; M_mem_wen = st;
    M_mem_op = op; M_mem_addr = addr; M_mem_wdata = wd;
    for (int c = 0; c <= a_dly; c++) begin
      data_addr_ok = (c == a_dly);
      @(negedge clk);
      chk("req_addr_phase", {31'h0, data_req}, 32'd1);
      chk("bus_addr", data_addr, e_addr);
      chk("bus_wr", {31'h0, data_wr}, {31'h0, st});
      chk("bus_size", {30'h0, data_size}, {30'h0, e_size});
      chk("bus_wstrb", {28'h0, data_wstrb}, {28'h0, e_strb});
      if (st) chk("bus_wdata", data_wdata, e_wdata);
      chk("stall_addr_phase", {31'h0, M_mem_stall}, 32'd1);
      @(posedge clk); #1;
    end
    data_addr_ok = 1'b0;
    for (int c = 0; c <= d_dly; c++) begin
      data_data_ok = (c == d_dly);
      data_rdata   = (c == d_dly) ? rd : $urandom();
      @(negedge clk);
      chk("req_data_phase", {31'h0, data_req}, 32'd0);
      chk("stall_data_phase", {31'h0, M_mem_stall}, 32'd1);
      @(posedge clk); #1;
    end
    data_data_ok = 1'b0;
    @(negedge clk);
    chk("stall_done", {31'h0, M_mem_stall}, 32'd0);
    chk("load_result", M_mem_rdata, e_rdata);
    M_pipe_ena = 1'b1;
    @(posedge clk); #1;
    M_pipe_ena = 1'b0; M_mem_en = 1'b0; M_mem_ren = 1'b0; M_mem_wen = 1'b0;
    last_rdata = e_rdata;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t       tbl [11];
  logic [5:0] ops [8];

  initial begin
    tbl[0]  = '{OP_LW,  32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 32'h1000_0004, 2'd2, 4'b0000, 32'h0,         32'hDEAD_BEEF};
    tbl[1]  = '{OP_LB,  32'h1000_0003, 32'h0,         32'h80FF_FFFF, 32'h1000_0003, 2'd0, 4'b0000, 32'h0,         32'hFFFF_FF80};
    tbl[2]  = '{OP_LBU, 32'h1000_0003, 32'h0,         32'h80FF_FFFF, 32'h1000_0003, 2'd0, 4'b0000, 32'h0,         32'h0000_0080};
    tbl[3]  = '{OP_SH,  32'h1000_0002, 32'h0000_1234, 32'h0,         32'h1000_0002, 2'd1, 4'b1100, 32'h1234_1234, 32'h0};
    tbl[4]  = '{OP_LH,  32'h1000_0002, 32'h0,         32'h8001_7FFF, 32'h1000_0002, 2'd1, 4'b0000, 32'h0,         32'hFFFF_8001};
    tbl[5]  = '{OP_LH,  32'h1000_0000, 32'h0,         32'h8001_7FFF, 32'h1000_0000, 2'd1, 4'b0000, 32'h0,         32'h0000_7FFF};
    tbl[6]  = '{OP_LHU, 32'h1000_0006, 32'h0,         32'h8001_7FFF, 32'h1000_0006, 2'd1, 4'b0000, 32'h0,         32'h0000_8001};
    tbl[7]  = '{OP_SB,  32'h1000_0001, 32'h0000_00A5, 32'h0,         32'h1000_0001, 2'd0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    tbl[8]  = '{OP_SW,  32'h1000_0008, 32'h1234_5678, 32'h0,         32'h1000_0008, 2'd2, 4'b1111, 32'h1234_5678, 32'h0};
    tbl[9]  = '{OP_LB,  32'h1000_0000, 32'h0,         32'h1234_567F, 32'h1000_0000, 2'd0, 4'b0000, 32'h0,         32'h0000_007F};
    tbl[10] = '{OP_LBU, 32'h1000_0002, 32'h0,         32'h12C4_5678, 32'h1000_0002, 2'd0, 4'b0000, 32'h0,         32'h0000_00C4};
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

    rst = 1'b0;
    M_mem_en = 1'b0; M_mem_ren = 1'b0; M_mem_wen = 1'b0; M_mem_op = 6'h0;
    M_mem_addr = 32'h0; M_mem_wdata = 32'h0; M_flush = 1'b0; M_pipe_ena = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    last_rdata = 32'h0;

    // Reset state
    #12;
    chk("rst_req", {31'h0, data_req}, 32'd0);
    chk("rst_stall", {31'h0, M_mem_stall}, 32'd0);
    chk("rst_rdata", M_mem_rdata, 32'h0);
    chk("rst_wr", {31'h0, data_wr}, 32'd0);
    chk("rst_wstrb", {28'h0, data_wstrb}, 32'd0);
    chk("rst_flags", {30'h0, M_adel, M_ades}, 32'd0);
    chk("rst_badv", M_badvaddr, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed vector table, minimum latency
    for (int i = 0; i < 11; i++)
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rd, 0, 0, tbl[i].e_addr,
              tbl[i].e_size, tbl[i].e_strb, tbl[i].e_wdata, tbl[i].e_rdata);

    // Misaligned accesses
`ifdef DMEM_ALIGN_CHECK_EN
    M_mem_en = 1'b1; M_mem_ren = 1'b1; M_mem_op = OP_LW; M_mem_addr = 32'h1000_0002;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("adel_set", {31'h0, M_adel}, 32'd1);
      chk("adel_no_ades", {31'h0, M_ades}, 32'd0);
      chk("adel_badv", M_badvaddr, 32'h1000_0002);
      chk("adel_no_req", {31'h0, data_req}, 32'd0);
      chk("adel_no_stall", {31'h0, M_mem_stall}, 32'd0);
      @(posedge clk); #1;
    end
    M_mem_ren = 1'b0; M_mem_wen = 1'b1; M_mem_op = OP_SW; M_mem_addr = 32'h1000_0001;
    @(negedge clk);
    chk("ades_set", {31'h0, M_ades}, 32'd1);
    chk("ades_no_adel", {31'h0, M_adel}, 32'd0);
    chk("ades_badv", M_badvaddr, 32'h1000_0001);
    chk("ades_no_req", {31'h0, data_req}, 32'd0);
    @(posedge clk); #1;
    M_mem_en = 1'b0; M_mem_wen = 1'b0;
    @(negedge clk);
    chk("flags_clear_badv", M_badvaddr, 32'h0);
    @(posedge clk); #1;
`else
    M_mem_en = 1'b1; M_mem_ren = 1'b1; M_mem_op = OP_LW; M_mem_addr = 32'h1000_0002; M_flush = 1'b1;
    @(negedge clk);
    chk("nochk_adel", {31'h0, M_adel}, 32'd0);
    chk("nochk_badv", M_badvaddr, 32'h0);
    chk("flush_no_req", {31'h0, data_req}, 32'd0);
    @(posedge clk); #1;
    M_flush = 1'b0; M_mem_en = 1'b0; M_mem_ren = 1'b0;
    run_txn(OP_LW, 32'h1000_0002, 32'h0, 32'hCAFE_F00D, 0, 1, 32'h1000_0000, 2'd2, 4'b0000, 32'h0, 32'hCAFE_F00D);
    run_txn(OP_LH, 32'h1000_0003, 32'h0, 32'h8001_7FFF, 1, 0, 32'h1000_0002, 2'd1, 4'b0000, 32'h0, 32'hFFFF_8001);
    run_txn(OP_SW, 32'h1000_0003, 32'h1122_3344, 32'h0, 0, 0, 32'h1000_0000, 2'd2, 4'b1111, 32'h1122_3344, 32'h0);
`endif

    // Seed a nonzero result, then flush in DATA before data_ok and drain the stale beat
    run_txn(OP_LW, 32'h1000_000C, 32'h0, 32'h5A5A_1234, 0, 0, 32'h1000_000C, 2'd2, 4'b0000, 32'h0, 32'h5A5A_1234);
    M_mem_en = 1'b1; M_mem_ren = 1'b1; M_mem_op = OP_LW; M_mem_addr = 32'h1000_0010; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; M_flush = 1'b1;
    @(negedge clk);
    chk("flush_data_req", {31'h0, data_req}, 32'd0);
    @(posedge clk); #1;
    M_flush = 1'b0; M_mem_addr = 32'h1000_0020;
    @(negedge clk);
    chk("drain_req", {31'h0, data_req}, 32'd0);
    chk("drain_stall", {31'h0, M_mem_stall}, 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hBADB_AD00;
    @(negedge clk);
    chk("drain_ok_req", {31'h0, data_req}, 32'd0);
    chk("drain_ok_stall", {31'h0, M_mem_stall}, 32'd1);
    @(posedge clk); #1;
    data_data_ok = 1'b0; data_rdata = 32'h0;
    @(negedge clk);
    chk("stale_discarded", M_mem_rdata, last_rdata);
    @(posedge clk); #1;
    M_mem_en = 1'b0; M_mem_ren = 1'b0;
    run_txn(OP_LW, 32'h1000_0020, 32'h0, 32'h600D_F00D, 0, 0, 32'h1000_0020, 2'd2, 4'b0000, 32'h0, 32'h600D_F00D);

    // Flush coinciding with data_ok: data dropped, unit back in IDLE
    M_mem_en = 1'b1; M_mem_ren = 1'b1; M_mem_op = OP_LW; M_mem_addr = 32'h1000_0030; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0; M_flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    M_flush = 1'b0; data_data_ok = 1'b0; M_mem_en = 1'b0; M_mem_ren = 1'b0;
    @(negedge clk);
    chk("flush_ok_discard", M_mem_rdata, last_rdata);
    @(posedge clk); #1;
    run_txn(OP_LHU, 32'h1000_0032, 32'h0, 32'hFEDC_0000, 3, 2, 32'h1000_0032, 2'd1, 4'b0000, 32'h0, 32'h0000_FEDC);

    // Reset pulsed while the address phase is stalled
    M_mem_en = 1'b1; M_mem_ren = 1'b1; M_mem_op = OP_LW; M_mem_addr = 32'h1000_0040;
    @(posedge clk); #1;
    @(negedge clk);
    chk("held_req", {31'h0, data_req}, 32'd1);
    @(posedge clk); #2;
    M_mem_en = 1'b0; M_mem_ren = 1'b0; rst = 1'b0;
    #1;
    chk("async_rst_req", {31'h0, data_req}, 32'd0);
    chk("async_rst_stall", {31'h0, M_mem_stall}, 32'd0);
    chk("async_rst_rdata", M_mem_rdata, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_idle", {31'h0, data_req}, 32'd0);
    @(posedge clk); #1;
    last_rdata = 32'h0;

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [5:0]  op;
      logic [31:0] a, wd, rd;
      op = ops[$urandom_range(0, 7)];
      a  = $urandom(); wd = $urandom(); rd = $urandom();
`ifdef DMEM_ALIGN_CHECK_EN
      a = a - (a % nbytes(op));
`endif
      run_txn(op, a, wd, rd, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              m_addr(op, a), m_size(op), m_strb(op, a), m_wdata(op, wd), m_load(op, a, rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
